// File: rtl/serial_negate_deser.sv
// serial_negate_deser
// Receive end of the bit-serial two's-complement link. An LSB-first serial
// stream is negated again bit by bit and assembled into a parallel word. The
// word is presented with a one-cycle valid strobe.
//
// Negation rule: copy bits up to and including the first '1', then invert
// every later bit. seen_one remembers whether that first '1' has passed, and
// it is cleared at the start of every word.
//
// Optional feature: define SERIAL_PARITY_EN to expect one trailing even-parity
// bit after every word. The word period then becomes WIDTH+1 clocks, and
// par_err reports a mismatch. In the default build there is no parity state
// and par_err is tied low.
module serial_negate_deser #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             i,
    input  logic             frame,
    output logic [WIDTH-1:0] y_word,
    output logic             valid,
    output logic             ovf,
    output logic             frame_err,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

    // cnt_q holds the number of data bits already sampled in the current
    // word. The edge that sees cnt_q == LAST_CNT samples the MSB.
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_e;

    // One bit of the serial two's-complement negation.
    function automatic logic neg_bit(input logic raw_bit, input logic seen_one);
        return raw_bit ^ seen_one;
    endfunction

    // The most negative input value negates to itself: bits 0..WIDTH-2 are
    // all zero (no '1' seen yet) and the raw MSB is '1'.
    function automatic logic ovf_bit(input logic seen_one, input logic raw_msb);
        return (~seen_one) & raw_msb;
    endfunction

`ifdef SERIAL_PARITY_EN
    // With even parity, the raw ones plus the parity bit must total an even
    // count. A set result means the parity check failed.
    function automatic logic parity_mismatch(input logic raw_acc, input logic par_bit);
        return raw_acc ^ par_bit;
    endfunction
`endif

    // Architectural state.
    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             seen_one_q,  seen_one_d;
    logic [WIDTH-1:0] sr_q,        sr_d;
    logic [WIDTH-1:0] y_word_q,    y_word_d;
    logic             valid_q,     valid_d;
    logic             ovf_q,       ovf_d;
    logic             frame_err_q, frame_err_d;
`ifdef SERIAL_PARITY_EN
    logic             par_err_q,   par_err_d;
    logic             par_acc_q,   par_acc_d;    // running XOR of raw data bits
    logic             ovf_pend_q,  ovf_pend_d;   // ovf result held until the parity bit
`endif

    // Decoded bit for this edge, and the shift register after inserting it.
    logic             out_bit_s;
    logic [WIDTH-1:0] word_s;

    // Negate the incoming bit and form the shift-register image including it.
    always_comb begin
        out_bit_s         = neg_bit(i, seen_one_q);
        word_s            = sr_q >> 1'b1;
        word_s[WIDTH-1]   = out_bit_s;
    end

    // Next-state logic for the receive FSM, the datapath and the output registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_one_d  = seen_one_q;
        sr_d        = sr_q;
        y_word_d    = y_word_q;
        valid_d     = 1'b0;
        ovf_d       = ovf_q;
        frame_err_d = 1'b0;
`ifdef SERIAL_PARITY_EN
        par_err_d   = par_err_q;
        par_acc_d   = par_acc_q;
        ovf_pend_d  = ovf_pend_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (frame) begin
                    // Bit 0 of a new word. Negation restarts, so the bit passes unchanged.
                    state_d    = ST_SHIFT;
                    cnt_d      = CNT_ONE;
                    seen_one_d = i;
                    sr_d       = {i, {(WIDTH-1){1'b0}}};
`ifdef SERIAL_PARITY_EN
                    par_acc_d  = i;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (frame) begin
                    // Early frame: drop the partial word and restart on this bit.
                    frame_err_d = 1'b1;
                    state_d     = ST_SHIFT;
                    cnt_d       = CNT_ONE;
                    seen_one_d  = i;
                    sr_d        = {i, {(WIDTH-1){1'b0}}};
`ifdef SERIAL_PARITY_EN
                    par_acc_d   = i;
`endif
                end else if (cnt_q == LAST_CNT) begin
                    // MSB sampled: the data word is complete.
`ifdef SERIAL_PARITY_EN
                    state_d    = ST_PAR;
                    cnt_d      = CW'(cnt_q + CNT_ONE);
                    sr_d       = word_s;
                    seen_one_d = seen_one_q | i;
                    par_acc_d  = par_acc_q ^ i;
                    ovf_pend_d = ovf_bit(seen_one_q, i);
`else
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                    sr_d       = word_s;
                    seen_one_d = 1'b0;
                    y_word_d   = word_s;
                    ovf_d      = ovf_bit(seen_one_q, i);
                    valid_d    = 1'b1;
`endif
                end else begin
                    state_d    = ST_SHIFT;
                    cnt_d      = CW'(cnt_q + CNT_ONE);
                    sr_d       = word_s;
                    seen_one_d = seen_one_q | i;
`ifdef SERIAL_PARITY_EN
                    par_acc_d  = par_acc_q ^ i;
`endif
                end
            end

`ifdef SERIAL_PARITY_EN
            ST_PAR: begin
                if (frame) begin
                    // A frame in place of the parity bit is also an early frame.
                    frame_err_d = 1'b1;
                    state_d     = ST_SHIFT;
                    cnt_d       = CNT_ONE;
                    seen_one_d  = i;
                    sr_d        = {i, {(WIDTH-1){1'b0}}};
                    par_acc_d   = i;
                end else begin
                    // Parity bit sampled: publish the word and the parity result.
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                    seen_one_d = 1'b0;
                    y_word_d   = sr_q;
                    ovf_d      = ovf_pend_q;
                    par_err_d  = parity_mismatch(par_acc_q, i);
                    valid_d    = 1'b1;
                end
            end
`endif

            default: begin
                // Unreachable encoding: recover to IDLE.
                state_d    = ST_IDLE;
                cnt_d      = CNT_ZERO;
                seen_one_d = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-high reset.
    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_ZERO;
            seen_one_q  <= 1'b0;
            sr_q        <= {WIDTH{1'b0}};
            y_word_q    <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef SERIAL_PARITY_EN
            par_err_q   <= 1'b0;
            par_acc_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seen_one_q  <= seen_one_d;
            sr_q        <= sr_d;
            y_word_q    <= y_word_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            frame_err_q <= frame_err_d;
`ifdef SERIAL_PARITY_EN
            par_err_q   <= par_err_d;
            par_acc_q   <= par_acc_d;
            ovf_pend_q  <= ovf_pend_d;
`endif
        end
    end

    assign y_word    = y_word_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;
    assign frame_err = frame_err_q;
`ifdef SERIAL_PARITY_EN
    assign par_err   = par_err_q;
`else
    assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_negate_deser.sv
// Testbench for serial_negate_deser (WIDTH=8). Expected words are pushed when
// a word is sent. A monitor pops and compares them on every valid strobe.
// The parity case runs only when SERIAL_PARITY_EN is defined.
module tb_serial_negate_deser;

    logic       t_clk;
    logic       r;
    logic       i;
    logic       frame;
    logic [7:0] y_word;
    logic       valid;
    logic       ovf;
    logic       frame_err;
    logic       par_err;

    typedef struct packed {
        logic [7:0] y;
        logic       ovf;
        logic       par;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_errors = 0;
    int         fe_seen  = 0;
    logic [7:0] last_y   = 8'h00;

    serial_negate_deser #(.WIDTH(8)) dut (
        .t_clk     (t_clk),
        .r         (r),
        .i         (i),
        .frame     (frame),
        .y_word    (y_word),
        .valid     (valid),
        .ovf       (ovf),
        .frame_err (frame_err),
        .par_err   (par_err)
    );

    initial t_clk = 1'b0;
    always #5 t_clk = ~t_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each valid strobe against the oldest expected word.
    always @(negedge t_clk) begin
        if (!r) begin
            if (frame_err) fe_seen++;
            if (valid) begin
                chk("valid_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("y_word", {24'd0, y_word}, {24'd0, mon_e.y});
                    chk("ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
                    chk("par_err", {31'd0, par_err}, {31'd0, mon_e.par});
                end
            end
        end
    end

    // Drive one bit. The next posedge samples it, and the task returns on the following negedge.
    task automatic send_bit(input logic b, input logic f);
        i     = b;
        frame = f;
        @(negedge t_clk);
    endtask

    // Send a full word (plus parity when enabled) and queue its expected result.
    task automatic send_word(input logic [7:0] raw, input logic [7:0] ey, input logic eovf,
                             input logic bad_par, input logic chk_fe);
        exp_t e;
        e.y   = ey;
        e.ovf = eovf;
`ifdef SERIAL_PARITY_EN
        e.par = bad_par;
`else
        e.par = 1'b0;
`endif
        exp_q.push_back(e);
        send_bit(raw[0], 1'b1);
        if (chk_fe) begin
            chk("frame_err_pulse", {31'd0, frame_err}, 32'd1);
            chk("y_hold_after_fe", {24'd0, y_word}, {24'd0, last_y});
        end
        for (int k = 1; k < 8; k++) send_bit(raw[k], 1'b0);
`ifdef SERIAL_PARITY_EN
        send_bit((^raw) ^ bad_par, 1'b0);
`endif
        chk("valid_latency", {31'd0, valid}, 32'd1);
        last_y = ey;
    endtask

    // Send the first nbits of a word without completing it.
    task automatic send_partial(input logic [7:0] raw, input int nbits);
        send_bit(raw[0], 1'b1);
        for (int k = 1; k < nbits; k++) send_bit(raw[k], 1'b0);
    endtask

    // Directed vectors: raw input, hand-computed negation, overflow flag.
    logic [7:0] v_raw [7] = '{8'hFB, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'hAA, 8'h01};
    logic [7:0] v_y   [7] = '{8'h05, 8'h80, 8'h00, 8'h81, 8'h01, 8'h56, 8'hFF};
    logic       v_ovf [7] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};

    initial begin
        r     = 1'b1;
        i     = 1'b1;
        frame = 1'b0;

        // Reset held for two clocks with activity on the inputs.
        for (int k = 0; k < 2; k++) begin
            frame = ~frame;
            @(negedge t_clk);
            chk("rst_valid", {31'd0, valid}, 32'd0);
            chk("rst_y_word", {24'd0, y_word}, 32'd0);
            chk("rst_ovf", {31'd0, ovf}, 32'd0);
            chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
            chk("rst_par_err", {31'd0, par_err}, 32'd0);
        end
        r     = 1'b0;
        frame = 1'b0;
        i     = 1'b0;
        @(negedge t_clk);
        chk("idle_valid", {31'd0, valid}, 32'd0);

        // Back-to-back words with no idle cycle between them.
        for (int k = 0; k < 7; k++) send_word(v_raw[k], v_y[k], v_ovf[k], 1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("valid_one_cycle", {31'd0, valid}, 32'd0);

        // Early frame at bit 4 of 0xFB, restarting as word 0x01.
        send_partial(8'hFB, 4);
        chk("y_hold_partial", {24'd0, y_word}, {24'd0, last_y});
        send_word(8'h01, 8'hFF, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset pulse while bit 3 is on the line.
        send_partial(8'hFB, 3);
        i     = 1'b1;
        frame = 1'b0;
        #2 r = 1'b1;
        #2 r = 1'b0;
        @(negedge t_clk);
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_y_word", {24'd0, y_word}, 32'd0);
        last_y = 8'h00;
        send_word(8'h02, 8'hFE, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_PARITY_EN
        send_word(8'hFB, 8'h05, 1'b0, 1'b0, 1'b0);
        send_word(8'hFB, 8'h05, 1'b0, 1'b1, 1'b0);
`endif

        // Drain with a bounded wait, then check the frame-error count.
        i     = 1'b0;
        frame = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge t_clk);
        chk("queue_drain", exp_q.size(), 32'd0);
        repeat (4) @(negedge t_clk);
        chk("frame_err_count", fe_seen, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
